seq_detect_sched: RTL and testbench

- Shares one programmable 4-bit Moore sequence-detector engine among NREQ requesters.
- Each requester submits a WORD_W-bit word. The block arbitrates round-robin, serialises the granted word MSB-first through the detector, and counts overlapping pattern hits.
- It returns the count with a one-cycle done strobe.
- It is the scheduler and configurator for the serial 1010-style detector datapath used in the lab experiments.

---
 rtl/seq_detect_sched.sv | 176 +++++++++++++++++
 tb/tb_seq_detect_sched.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_sched.sv
// Round-robin scheduler sharing one programmable 4-bit Moore sequence detector among NREQ requesters.
// Build option: define SEQDET_NO_OVERLAP_EN for non-overlapping detection.
module seq_detect_sched #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned WORD_W = 16,
    parameter int unsigned CNT_W  = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             pattern,
    input  logic                   pat_load,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*WORD_W-1:0] req_data,
    output logic [NREQ-1:0]        gnt,
    output logic                   busy,
    output logic                   bit_out,
    output logic                   match,
    output logic                   done,
    output logic [2:0]             done_id,
    output logic [CNT_W-1:0]       match_cnt
);

    localparam int unsigned BCW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StShift,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          ptr_q;
    logic [2:0]          idx_q;
    logic [WORD_W-1:0]   sreg_q;
    // The fourth history bit is the bit currently on bit_out, so only three are stored.
    logic [2:0]          hist_q;
    logic [2:0]          fill_q;
    logic                match_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [BCW-1:0]      bcnt_q;
    logic [3:0]          pat_q;

    logic                any_req;
    logic [2:0]          pick;
    logic [WORD_W-1:0]   word_sel;
    logic                ser;
    logic                hit;
    logic [2:0]          ptr_next;

    // Descending scan so the requester closest at-or-after the pointer wins.
    always_comb begin
        int j;
        any_req  = 1'b0;
        pick     = '0;
        word_sel = '0;
        j        = 0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            j = int'(ptr_q) + i;
            if (j >= int'(NREQ)) begin
                j = j - int'(NREQ);
            end
            if (req[j]) begin
                any_req  = 1'b1;
                pick     = 3'(j);
                word_sel = req_data[j*WORD_W +: WORD_W];
            end
        end
    end

    assign ser      = sreg_q[WORD_W-1];
    assign hit      = (fill_q >= 3'd3) && ({hist_q, ser} == pat_q);
    assign ptr_next = (idx_q == 3'(NREQ - 1)) ? 3'd0 : idx_q + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt     = '0;
        bit_out = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StGrant;
                end
            end
            StGrant: begin
                gnt     = NREQ'(1) << idx_q;
                state_d = StShift;
            end
            StShift: begin
                bit_out = ser;
                if (bcnt_q == BCW'(WORD_W - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy      = (state_q != StIdle);
    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign done_id   = done ? idx_q : 3'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            idx_q   <= '0;
            sreg_q  <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            pat_q   <= 4'b1010;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pat_load) begin
                        pat_q <= pattern;
                    end
                    if (any_req) begin
                        idx_q   <= pick;
                        sreg_q  <= word_sel;
                        hist_q  <= '0;
                        fill_q  <= '0;
                        match_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                StGrant: begin
                    ptr_q  <= ptr_next;
                    bcnt_q <= '0;
                end
                StShift: begin
                    hist_q  <= {hist_q[1:0], ser};
                    sreg_q  <= sreg_q << 1;
                    bcnt_q  <= bcnt_q + BCW'(1);
                    match_q <= hit;
                    if (hit && (cnt_q != '1)) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`ifdef SEQDET_NO_OVERLAP_EN
                    // Restart the fill so the next hit needs four fresh bits.
                    if (hit) begin
                        fill_q <= '0;
                    end else if (fill_q != 3'd4) begin
                        fill_q <= fill_q + 3'd1;
                    end
`else
                    if (fill_q != 3'd4) begin
                        fill_q <= fill_q + 3'd1;
                    end
`endif
                end
                StDone: begin
                    match_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_sched.sv
// Randomised self-checking bench for seq_detect_sched against a window-scan reference model.
module tb_seq_detect_sched;

    localparam int NREQ   = 4;
    localparam int WORD_W = 16;
    localparam int CNT_W  = 5;
`ifdef SEQDET_NO_OVERLAP_EN
    localparam bit OVL = 1'b0;
`else
    localparam bit OVL = 1'b1;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic [3:0]             pattern;
    logic                   pat_load;
    logic [NREQ-1:0]        req;
    logic [NREQ*WORD_W-1:0] req_data;
    logic [NREQ-1:0]        gnt;
    logic                   busy;
    logic                   bit_out;
    logic                   match;
    logic                   done;
    logic [2:0]             done_id;
    logic [CNT_W-1:0]       match_cnt;

    seq_detect_sched #(.NREQ(NREQ), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .pattern  (pattern),
        .pat_load (pat_load),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .busy     (busy),
        .bit_out  (bit_out),
        .match    (match),
        .done     (done),
        .done_id  (done_id),
        .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [3:0] mdl_pat;
    int         mdl_ptr;

    logic [NREQ-1:0]    cap_g;
    logic [WORD_W:0]    cap_trace;
    logic [WORD_W-1:0]  cap_bits;
    logic               cap_done;
    logic [2:0]         cap_id;
    logic [CNT_W-1:0]   cap_cnt;
    bit                 cap_to;
    bit                 cap_ctrl_ok;
    int                 cap_waits;

    // Expected match trace: bit k is the match level k cycles into SHIFT (k=WORD_W is DONE).
    function automatic logic [WORD_W:0] model_trace(input logic [WORD_W-1:0] w,
                                                    input logic [3:0] p);
        logic [WORD_W:0] t;
        logic [3:0]      win;
        int              last;
        t    = '0;
        last = -100;
        for (int i = 3; i < WORD_W; i++) begin
            win = w[WORD_W+2-i -: 4];
            if (win == p && (OVL || (i - last) >= 4)) begin
                t[i+1] = 1'b1;
                last   = i;
            end
        end
        return t;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] mask, input int ptr);
        for (int off = 0; off < NREQ; off++) begin
            if (mask[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_word(input int i, input logic [WORD_W-1:0] w);
        req_data[i*WORD_W +: WORD_W] = w;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        req      = '0;
        pat_load = 1'b0;
        pattern  = '0;
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        mdl_pat = 4'b1010;
        mdl_ptr = 0;
    endtask

    task automatic load_pattern(input logic [3:0] p);
        pattern  = p;
        pat_load = 1'b1;
        @(negedge clk);
        pat_load = 1'b0;
        mdl_pat  = p;
    endtask

    // Observes one job from the grant through DONE; stimulus side-effects only.
    task automatic capture(input bit drop_req, input bit mid_load);
        cap_to      = 1'b0;
        cap_waits   = 0;
        cap_ctrl_ok = 1'b1;
        cap_trace   = '0;
        @(negedge clk);
        while (gnt == '0 && cap_waits < 40) begin
            cap_waits++;
            @(negedge clk);
        end
        if (gnt == '0) begin
            cap_to = 1'b1;
            return;
        end
        cap_g = gnt;
        if (!busy) cap_ctrl_ok = 1'b0;
        pat_load = 1'b0;
        if (drop_req) req = '0;
        for (int k = 0; k < WORD_W; k++) begin
            @(negedge clk);
            cap_bits[WORD_W-1-k] = bit_out;
            cap_trace[k]         = match;
            if (!busy || done || gnt != '0) cap_ctrl_ok = 1'b0;
            if (mid_load && k == 3) begin
                pattern  = 4'b0000;
                pat_load = 1'b1;
            end else begin
                pat_load = 1'b0;
            end
        end
        @(negedge clk);
        cap_trace[WORD_W] = match;
        cap_done          = done;
        cap_id            = done_id;
        cap_cnt           = match_cnt;
        if (!busy || gnt != '0) cap_ctrl_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        pat_load = 1'b0;
        pattern = '0;
        req_data = '0;
        #1;
        checks++;
        if ({gnt, busy, bit_out, match, done, done_id, match_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0",
                     {gnt, busy, bit_out, match, done, done_id, match_cnt});
        end
        do_reset();
        checks++;
        if ({gnt, busy, bit_out, match, done, done_id, match_cnt} !== '0) begin
            errors++;
            $display("FAIL post_reset_outputs got=%h want=0",
                     {gnt, busy, bit_out, match, done, done_id, match_cnt});
        end
    endtask

    task automatic test_basic();
        logic [WORD_W:0] exp_t;
        logic [CNT_W-1:0] held;
        do_reset();
        set_word(0, 16'hAAAA);
        req   = 4'b0001;
        exp_t = model_trace(16'hAAAA, mdl_pat);
        capture(1'b1, 1'b0);
        checks++;
        if (cap_to) begin errors++; $display("FAIL basic_timeout got=none want=gnt"); end
        checks++;
        if (cap_g !== 4'b0001) begin
            errors++; $display("FAIL basic_gnt got=%b want=0001", cap_g);
        end
        checks++;
        if (cap_waits != 0) begin
            errors++; $display("FAIL basic_latency got=%0d want=0", cap_waits);
        end
        checks++;
        if (!cap_ctrl_ok) begin errors++; $display("FAIL basic_ctrl got=bad want=ok"); end
        checks++;
        if (cap_bits !== 16'hAAAA) begin
            errors++; $display("FAIL basic_bits got=%h want=aaaa", cap_bits);
        end
        checks++;
        if (cap_trace !== exp_t) begin
            errors++; $display("FAIL basic_trace got=%h want=%h", cap_trace, exp_t);
        end
        checks++;
        if (cap_done !== 1'b1 || cap_id !== 3'd0) begin
            errors++; $display("FAIL basic_done got=%b/%0d want=1/0", cap_done, cap_id);
        end
        checks++;
        if (cap_cnt !== CNT_W'($countones(exp_t))) begin
            errors++;
            $display("FAIL basic_cnt got=%0d want=%0d", cap_cnt, $countones(exp_t));
        end
        mdl_ptr = 1;
        held = cap_cnt;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || match !== 1'b0 || match_cnt !== held) begin
            errors++;
            $display("FAIL basic_idle got=%b%b%b/%0d want=000/%0d", done, busy, match,
                     match_cnt, held);
        end
    endtask

    task automatic test_back_to_back();
        logic [WORD_W:0] exp_t;
        do_reset();
        set_word(0, 16'h0000);
        set_word(2, 16'hAAAA);
        req = 4'b0101;
        capture(1'b0, 1'b0);
        checks++;
        if (cap_to || cap_g !== 4'b0001 || cap_cnt !== '0 || cap_id !== 3'd0) begin
            errors++;
            $display("FAIL b2b_first got=%b/%0d/%0d want=0001/0/0", cap_g, cap_id, cap_cnt);
        end
        exp_t = model_trace(16'hAAAA, mdl_pat);
        capture(1'b0, 1'b0);
        req = '0;
        checks++;
        if (cap_to || cap_g !== 4'b0100 || cap_id !== 3'd2) begin
            errors++; $display("FAIL b2b_second got=%b/%0d want=0100/2", cap_g, cap_id);
        end
        checks++;
        if (cap_waits != 1) begin
            errors++; $display("FAIL b2b_idle_gap got=%0d want=1", cap_waits);
        end
        checks++;
        if (cap_cnt !== CNT_W'($countones(exp_t)) || cap_trace !== exp_t) begin
            errors++;
            $display("FAIL b2b_cnt got=%0d/%h want=%0d/%h", cap_cnt, cap_trace,
                     $countones(exp_t), exp_t);
        end
        checks++;
        if (!cap_ctrl_ok) begin errors++; $display("FAIL b2b_ctrl got=bad want=ok"); end
        mdl_ptr = 3;
    endtask

    task automatic test_pattern_load();
        logic [WORD_W:0] exp_t;
        int              e;
        @(negedge clk);
        load_pattern(4'b1001);
        set_word(0, 16'h9999);
        e     = rr_pick(4'b0001, mdl_ptr);
        req   = 4'b0001;
        exp_t = model_trace(16'h9999, mdl_pat);
        capture(1'b1, 1'b1);
        checks++;
        if (cap_to || cap_g !== (NREQ'(1) << e)) begin
            errors++; $display("FAIL patload_gnt got=%b want=%0d", cap_g, e);
        end
        checks++;
        if (cap_cnt !== CNT_W'($countones(exp_t)) || cap_trace !== exp_t) begin
            errors++;
            $display("FAIL patload_cnt got=%0d/%h want=%0d/%h", cap_cnt, cap_trace,
                     $countones(exp_t), exp_t);
        end
        mdl_ptr = (e + 1) % NREQ;
    endtask

    task automatic test_single_hit();
        int e;
        @(negedge clk);
        load_pattern(4'b1010);
        set_word(1, 16'hA000);
        e   = rr_pick(4'b0010, mdl_ptr);
        req = 4'b0010;
        capture(1'b1, 1'b0);
        checks++;
        if (cap_to || cap_trace !== 17'h00010) begin
            errors++; $display("FAIL single_trace got=%h want=00010", cap_trace);
        end
        checks++;
        if (cap_cnt !== 5'd1 || cap_id !== 3'd1) begin
            errors++; $display("FAIL single_cnt got=%0d/%0d want=1/1", cap_cnt, cap_id);
        end
        mdl_ptr = (e + 1) % NREQ;
    endtask

    task automatic test_all_req();
        logic [WORD_W-1:0] w [NREQ];
        logic [WORD_W:0]   exp_t;
        int                e;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            w[i] = WORD_W'($urandom);
            set_word(i, w[i]);
        end
        req = '1;
        for (int n = 0; n < 5; n++) begin
            e     = rr_pick(4'b1111, mdl_ptr);
            exp_t = model_trace(w[e], mdl_pat);
            capture(1'b0, 1'b0);
            checks++;
            if (cap_to || cap_g !== (NREQ'(1) << e) || cap_id !== 3'(e)) begin
                errors++;
                $display("FAIL allreq_gnt n=%0d got=%b/%0d want=%0d", n, cap_g, cap_id, e);
            end
            checks++;
            if (cap_cnt !== CNT_W'($countones(exp_t)) || !cap_ctrl_ok) begin
                errors++;
                $display("FAIL allreq_cnt n=%0d got=%0d want=%0d", n, cap_cnt,
                         $countones(exp_t));
            end
            mdl_ptr = (e + 1) % NREQ;
        end
        req = '0;
    endtask

    task automatic test_random();
        logic [WORD_W-1:0] w [NREQ];
        logic [WORD_W:0]   exp_t;
        logic [NREQ-1:0]   mask;
        logic [3:0]        p;
        int                e;
        for (int n = 0; n < 12; n++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            if ($urandom_range(0, 1) == 1) begin
                p        = 4'($urandom);
                pattern  = p;
                pat_load = 1'b1;
                mdl_pat  = p;
            end
            for (int i = 0; i < NREQ; i++) begin
                w[i] = ($urandom_range(0, 2) == 0) ? {4{mdl_pat}} : WORD_W'($urandom);
                set_word(i, w[i]);
            end
            e     = rr_pick(mask, mdl_ptr);
            exp_t = model_trace(w[e], mdl_pat);
            req   = mask;
            capture(1'b1, 1'b0);
            checks++;
            if (cap_to || cap_g !== (NREQ'(1) << e) || cap_id !== 3'(e)) begin
                errors++;
                $display("FAIL rand_gnt n=%0d got=%b/%0d want=%0d", n, cap_g, cap_id, e);
            end
            checks++;
            if (cap_trace !== exp_t || cap_cnt !== CNT_W'($countones(exp_t))) begin
                errors++;
                $display("FAIL rand_trace n=%0d got=%h/%0d want=%h/%0d", n, cap_trace,
                         cap_cnt, exp_t, $countones(exp_t));
            end
            checks++;
            if (cap_bits !== w[e] || !cap_ctrl_ok || cap_done !== 1'b1) begin
                errors++;
                $display("FAIL rand_serial n=%0d got=%h want=%h", n, cap_bits, w[e]);
            end
            mdl_ptr = (e + 1) % NREQ;
        end
    endtask

    task automatic test_reset_mid();
        logic [WORD_W:0] exp_t;
        int              waits;
        @(negedge clk);
        load_pattern(4'b0110);
        set_word(1, 16'hAAAA);
        req   = 4'b0010;
        waits = 0;
        @(negedge clk);
        while (gnt == '0 && waits < 40) begin
            waits++;
            @(negedge clk);
        end
        req = '0;
        repeat (8) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b want=1", busy); end
        rst = 1'b1;
        #1;
        checks++;
        if ({gnt, busy, bit_out, match, done, done_id, match_cnt} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got=%h want=0",
                     {gnt, busy, bit_out, match, done, done_id, match_cnt});
        end
        @(negedge clk);
        rst     = 1'b0;
        mdl_pat = 4'b1010;
        mdl_ptr = 0;
        for (int i = 0; i < NREQ; i++) set_word(i, 16'hAAAA);
        exp_t = model_trace(16'hAAAA, mdl_pat);
        req   = '1;
        capture(1'b1, 1'b0);
        checks++;
        if (cap_to || cap_g !== 4'b0001) begin
            errors++; $display("FAIL mid_restart_gnt got=%b want=0001", cap_g);
        end
        checks++;
        if (cap_cnt !== CNT_W'($countones(exp_t)) || cap_trace !== exp_t) begin
            errors++;
            $display("FAIL mid_restart_cnt got=%0d want=%0d", cap_cnt, $countones(exp_t));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_pattern_load();
        test_single_hit();
        test_all_req();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
